// File: rtl/clb_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clb_cfg_pkg
//  Description : Shared definitions for the CLB configuration loader and for
//                the per-CLB configuration registers that consume CFG_DATA:
//                frame geometry, sync pattern, packed field offsets, loader
//                state encoding and error codes.
//  Revision    : 1.0  initial release
// ============================================================================
package clb_cfg_pkg;

    // ------------------------------------------------------------------
    // Stream geometry
    // ------------------------------------------------------------------
    localparam int          CFG_W    = 37;            // frame payload bits
    localparam logic [7:0]  PREAMBLE = 8'b1011_0010;  // sync pattern, MSB first
    localparam int          LEN_W    = 16;            // frame-count field width
    localparam int          CNT_W    = 6;             // bit counter width

    // ------------------------------------------------------------------
    // Packed payload layout (bit offset of each field's LSB)
    // MSB..LSB: mux2..mux6 selects, mem, comboption, o2m selects,
    //           DQmux1, DQmux2, floporlatch
    // ------------------------------------------------------------------
    localparam int c_SEL_W           = 2;
    localparam int c_MEM_W           = 16;
    localparam int c_OFF_MUX2SELECT  = 35;
    localparam int c_OFF_MUX3SELECT  = 33;
    localparam int c_OFF_MUX4SELECT  = 31;
    localparam int c_OFF_MUX5SELECT  = 29;
    localparam int c_OFF_MUX6SELECT  = 27;
    localparam int c_OFF_MEM         = 11;
    localparam int c_OFF_COMBOPTION  = 9;
    localparam int c_OFF_O2M1_0      = 8;
    localparam int c_OFF_O2M2_0      = 7;
    localparam int c_OFF_O2M3_0      = 6;
    localparam int c_OFF_O2M1_1      = 5;
    localparam int c_OFF_O2M2_1      = 4;
    localparam int c_OFF_O2M3_1      = 3;
    localparam int c_OFF_DQMUX1      = 2;
    localparam int c_OFF_DQMUX2      = 1;
    localparam int c_OFF_FLOPORLATCH = 0;

    // ------------------------------------------------------------------
    // Loader state encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_LENGTH = 3'd1,
        ST_FRAME  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } cfg_state_t;

    // ------------------------------------------------------------------
    // ERR_CODE values
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_BAD_LEN = 2'b01;
    localparam logic [1:0] c_ERR_PARITY  = 2'b10;

    // ------------------------------------------------------------------
    // Field extraction helpers for the configuration register side
    // ------------------------------------------------------------------
    function automatic logic [c_MEM_W-1:0] cfg_mem(input logic [CFG_W-1:0] d);
        return d[c_OFF_MEM +: c_MEM_W];
    endfunction

    function automatic logic [c_SEL_W-1:0] cfg_comboption(input logic [CFG_W-1:0] d);
        return d[c_OFF_COMBOPTION +: c_SEL_W];
    endfunction

    function automatic logic cfg_floporlatch(input logic [CFG_W-1:0] d);
        return d[c_OFF_FLOPORLATCH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/clb_cfg_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : clb_cfg_shifter
//  Description : Serial-in, MSB-first shift register with bit counter and
//                running XOR parity. Used as the preamble window, the
//                frame-count collector and the frame payload collector.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                clr  - synchronous clear at a field boundary (beats en)
//                en   - shift din in on this edge
//                din  - serial data bit
//                sreg - shift register contents, newest bit in LSB
//                cnt  - number of bits shifted since the last clear
//                par  - XOR of all bits shifted since the last clear
//  Revision    : 1.0  initial release
// ============================================================================
module clb_cfg_shifter
    import clb_cfg_pkg::*;
#(
    parameter int W = CFG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [W-1:0]     sreg,
    output logic [CNT_W-1:0] cnt,
    output logic             par
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sreg <= '0;
            cnt  <= '0;
            par  <= 1'b0;
        end else if (en) begin
            sreg <= {sreg[W-2:0], din};
            // Counter wraps harmlessly while hunting; it is only
            // inspected in the length and frame phases.
            cnt  <= cnt + CNT_W'(1);
            par  <= par ^ din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clb_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : clb_config_loader
//  Description : Serial configuration controller for the CLB array. Hunts
//                the bitstream for the preamble, reads a 16-bit frame count
//                N, then deserialises N parity-protected frames and writes
//                each one to CLB 0..N-1 with a one-cycle strobe.
//  Ports       : K         - clock, rising edge
//                RST       - synchronous active-high reset
//                PROG      - functional restart, next edge
//                DIN       - serial bitstream, MSB first
//                DIN_VALID - DIN sampled when high
//                CFG_WE    - one-cycle write strobe
//                CFG_ADDR  - target CLB index
//                CFG_DATA  - frame payload
//                BUSY      - reading frame count or frames
//                DONE      - sticky, all frames loaded
//                ERR       - sticky error
//                ERR_CODE  - 00 none, 01 bad length, 10 parity fail
//  Revision    : 1.0  initial release
// ============================================================================
module clb_config_loader #(
    parameter int         NUM_CLB  = 64,
    parameter int         CFG_W    = clb_cfg_pkg::CFG_W,
    parameter logic [7:0] PREAMBLE = clb_cfg_pkg::PREAMBLE,
    parameter int         AW       = $clog2(NUM_CLB)
) (
    input  logic             K,
    input  logic             RST,
    input  logic             PROG,
    input  logic             DIN,
    input  logic             DIN_VALID,
    output logic             CFG_WE,
    output logic [AW-1:0]    CFG_ADDR,
    output logic [CFG_W-1:0] CFG_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [1:0]       ERR_CODE
);

    import clb_cfg_pkg::*;

    // The shifter counts bits already held; the field's last bit is the
    // one arriving while the count equals (field length - 1).
    localparam logic [CNT_W-1:0] c_LEN_LAST = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] c_FRM_LAST = CNT_W'(CFG_W);     // parity bit
    localparam logic [LEN_W-1:0] c_NUM_CLB  = LEN_W'(NUM_CLB);
    localparam logic [LEN_W-1:0] c_ONE      = LEN_W'(1);

    cfg_state_t         r_state;
    logic [LEN_W-1:0]   r_n;
    logic [LEN_W-1:0]   r_frame_cnt;

    logic [CFG_W-1:0]   w_sreg;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_par;

    logic               w_active;
    logic               w_shift_en;
    logic [7:0]         w_window;
    logic [LEN_W-1:0]   w_len;
    logic               w_hunt_hit;
    logic               w_len_end;
    logic               w_frm_end;
    logic               w_len_bad;
    logic               w_par_ok;
    logic               w_last_frame;
    logic               w_clr;

    // ------------------------------------------------------------------
    // Boundary detection, looking at the bit being sampled this edge
    // ------------------------------------------------------------------
    assign w_active   = (r_state == ST_HUNT) || (r_state == ST_LENGTH) ||
                        (r_state == ST_FRAME);
    assign w_shift_en = DIN_VALID && w_active;

    // Sliding window including the incoming bit, so overlapping partial
    // matches fall out of the shift itself.
    assign w_window   = {w_sreg[6:0], DIN};
    assign w_len      = {w_sreg[LEN_W-2:0], DIN};

    assign w_hunt_hit = w_shift_en && (r_state == ST_HUNT)   && (w_window == PREAMBLE);
    assign w_len_end  = w_shift_en && (r_state == ST_LENGTH) && (w_cnt == c_LEN_LAST);
    assign w_frm_end  = w_shift_en && (r_state == ST_FRAME)  && (w_cnt == c_FRM_LAST);

    assign w_len_bad    = (w_len == '0) || (w_len > c_NUM_CLB);
    // Even parity over payload plus parity bit.
    assign w_par_ok     = ~(w_par ^ DIN);
    assign w_last_frame = (r_frame_cnt == (r_n - c_ONE));

    // PROG clears the shifter too, which discards any coincident bit.
    assign w_clr = PROG | w_hunt_hit | w_len_end | w_frm_end;

    clb_cfg_shifter #(
        .W (CFG_W)
    ) u_shifter (
        .clk  (K),
        .rst  (RST),
        .clr  (w_clr),
        .en   (w_shift_en),
        .din  (DIN),
        .sreg (w_sreg),
        .cnt  (w_cnt),
        .par  (w_par)
    );

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge K) begin
        if (RST || PROG) begin
            r_state     <= ST_HUNT;
            r_n         <= '0;
            r_frame_cnt <= '0;
            CFG_WE      <= 1'b0;
            CFG_ADDR    <= '0;
            CFG_DATA    <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
            ERR_CODE    <= c_ERR_NONE;
        end else begin
            CFG_WE <= 1'b0;

            case (r_state)
                ST_HUNT: begin
                    if (w_hunt_hit) begin
                        r_state <= ST_LENGTH;
                        BUSY    <= 1'b1;
                    end
                end

                ST_LENGTH: begin
                    if (w_len_end) begin
                        if (w_len_bad) begin
                            r_state  <= ST_ERROR;
                            BUSY     <= 1'b0;
                            ERR      <= 1'b1;
                            ERR_CODE <= c_ERR_BAD_LEN;
                        end else begin
                            r_state     <= ST_FRAME;
                            r_n         <= w_len;
                            r_frame_cnt <= '0;
                        end
                    end
                end

                ST_FRAME: begin
                    if (w_frm_end) begin
                        if (w_par_ok) begin
                            // Payload is everything before the parity bit.
                            CFG_WE      <= 1'b1;
                            CFG_ADDR    <= r_frame_cnt[AW-1:0];
                            CFG_DATA    <= w_sreg;
                            r_frame_cnt <= r_frame_cnt + c_ONE;
                            if (w_last_frame) begin
                                r_state <= ST_DONE;
                                BUSY    <= 1'b0;
                                DONE    <= 1'b1;
                            end
                        end else begin
                            r_state  <= ST_ERROR;
                            BUSY     <= 1'b0;
                            ERR      <= 1'b1;
                            ERR_CODE <= c_ERR_PARITY;
                        end
                    end
                end

                // DONE and ERROR are terminal until RST or PROG.
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clb_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clb_config_loader
//  Description : Self-checking bench for clb_config_loader. Table-driven
//                stream cases, randomized streams and hand-written reset /
//                restart sequences, all compared against a bitstream-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clb_config_loader;

    localparam int NUM_CLB = 64;
    localparam int CFG_W   = 37;
    localparam int AW      = 6;

    logic             K = 1'b0;
    logic             RST, PROG, DIN, DIN_VALID;
    logic             CFG_WE;
    logic [AW-1:0]    CFG_ADDR;
    logic [CFG_W-1:0] CFG_DATA;
    logic             BUSY, DONE, ERR;
    logic [1:0]       ERR_CODE;

    clb_config_loader #(
        .NUM_CLB (NUM_CLB)
    ) dut (
        .K         (K),
        .RST       (RST),
        .PROG      (PROG),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .CFG_WE    (CFG_WE),
        .CFG_ADDR  (CFG_ADDR),
        .CFG_DATA  (CFG_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .ERR_CODE  (ERR_CODE)
    );

    always #5 K = ~K;

    int cyc = 0;
    always @(posedge K) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    int               m_addr[$];
    logic [CFG_W-1:0] m_data[$];
    int               m_cyc[$];
    bit               m_done_at[$];
    int               err_cyc   = -1;
    int               done_cyc  = -1;
    bit               both_seen = 1'b0;

    always @(negedge K) begin
        if (CFG_WE) begin
            m_addr.push_back(int'(CFG_ADDR));
            m_data.push_back(CFG_DATA);
            m_cyc.push_back(cyc);
            m_done_at.push_back(DONE);
        end
        if (ERR && err_cyc < 0)   err_cyc  = cyc;
        if (DONE && done_cyc < 0) done_cyc = cyc;
        if (DONE && ERR)          both_seen = 1'b1;
    end

    task automatic clear_monitor();
        m_addr.delete(); m_data.delete(); m_cyc.delete(); m_done_at.delete();
        err_cyc = -1; done_cyc = -1; both_seen = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Stream construction and driving
    // ------------------------------------------------------------------
    logic stream[$];
    int   bit_cyc[$];

    task automatic push_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
    endtask

    task automatic push_frame(input logic [CFG_W-1:0] p, input bit bad);
        for (int i = CFG_W - 1; i >= 0; i--) stream.push_back(p[i]);
        stream.push_back((^p) ^ bad);
    endtask

    function automatic logic [CFG_W-1:0] rand_payload();
        return CFG_W'({$urandom(), $urandom()});
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge K); #1; end
    endtask

    task automatic drive_bit(input logic b);
        DIN = b; DIN_VALID = 1'b1;
        @(posedge K); #1;
        bit_cyc.push_back(cyc);
        DIN_VALID = 1'b0; DIN = 1'b0;
    endtask

    task automatic prog_pulse();
        PROG = 1'b1;
        @(posedge K); #1;
        PROG = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: parses the whole stream by the protocol rules
    // ------------------------------------------------------------------
    int               exp_addr[$];
    logic [CFG_W-1:0] exp_data[$];
    int               exp_idx[$];
    bit               exp_done, exp_err, exp_busy;
    logic [1:0]       exp_code;
    int               exp_end;

    task automatic model();
        logic [7:0]       win;
        logic [CFG_W-1:0] pl;
        logic             x;
        int               pos, p, n;
        exp_addr.delete(); exp_data.delete(); exp_idx.delete();
        exp_done = 0; exp_err = 0; exp_busy = 0; exp_code = 2'b00; exp_end = -1;
        win = 8'h00; pos = -1;
        for (int i = 0; i < stream.size(); i++) begin
            win = {win[6:0], stream[i]};
            if (win == 8'hB2) begin pos = i + 1; break; end
        end
        if (pos < 0) return;
        exp_busy = 1;
        if (pos + 16 > stream.size()) return;
        n = 0;
        for (int i = 0; i < 16; i++) n = n * 2 + int'(stream[pos + i]);
        if (n == 0 || n > NUM_CLB) begin
            exp_err = 1; exp_code = 2'b01; exp_busy = 0; exp_end = pos + 15;
            return;
        end
        p = pos + 16;
        for (int k = 0; k < n; k++) begin
            if (p + CFG_W + 1 > stream.size()) return;
            pl = '0; x = 1'b0;
            for (int i = 0; i < CFG_W; i++) begin
                pl = {pl[CFG_W-2:0], stream[p + i]};
                x  = x ^ stream[p + i];
            end
            x = x ^ stream[p + CFG_W];
            if (x) begin
                exp_err = 1; exp_code = 2'b10; exp_busy = 0; exp_end = p + CFG_W;
                return;
            end
            exp_addr.push_back(k);
            exp_data.push_back(pl);
            exp_idx.push_back(p + CFG_W);
            p = p + CFG_W + 1;
        end
        exp_done = 1; exp_busy = 0; exp_end = p - 1;
    endtask

    // Drive the current stream, then compare against the model.
    task automatic run_stream(input bit gaps);
        int nw;
        clear_monitor();
        bit_cyc.delete();
        for (int i = 0; i < stream.size(); i++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive_bit(stream[i]);
        end
        idle(4);
        model();
        check("n_writes", 64'(m_addr.size()), 64'(exp_addr.size()));
        nw = (m_addr.size() < exp_addr.size()) ? m_addr.size() : exp_addr.size();
        for (int k = 0; k < nw; k++) begin
            check("wr_addr",  64'(m_addr[k]), 64'(exp_addr[k]));
            check("wr_data",  64'(m_data[k]), 64'(exp_data[k]));
            check("wr_cycle", 64'(m_cyc[k]),  64'(bit_cyc[exp_idx[k]]));
        end
        check("DONE",     64'(DONE),     64'(exp_done));
        check("ERR",      64'(ERR),      64'(exp_err));
        check("ERR_CODE", 64'(ERR_CODE), 64'(exp_code));
        check("BUSY",     64'(BUSY),     64'(exp_busy));
        check("done_err_excl", 64'(both_seen), 64'(0));
        if (exp_done) begin
            check("done_cycle", 64'(done_cyc), 64'(bit_cyc[exp_end]));
            if (m_done_at.size() > 0)
                check("done_with_last_we", 64'(m_done_at[m_done_at.size()-1]), 64'(1));
        end else begin
            check("no_done", 64'(done_cyc < 0), 64'(1));
        end
        if (exp_err)
            check("err_cycle", 64'(err_cyc), 64'(bit_cyc[exp_end]));
    endtask

    // ------------------------------------------------------------------
    // Table of stream cases
    // ------------------------------------------------------------------
    typedef struct {
        int         n_len;
        int         n_frames;
        int         bad_frame;
        bit         false_start;
        bit         fixed_payload;
        bit         gaps;
        int         exp_nwr;
        bit         exp_done;
        bit         exp_err;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[8];

    initial begin
        RST = 1'b1; PROG = 1'b0; DIN = 1'b0; DIN_VALID = 1'b0;
        repeat (3) @(posedge K);
        #1;
        check("reset_outputs", 64'({CFG_WE, CFG_ADDR, CFG_DATA, BUSY, DONE, ERR, ERR_CODE}), 64'(0));
        RST = 1'b0;
        idle(2);

        //          N   frm bad fs fix gap nwr done err code
        vecs[0] = '{2,  2,  -1, 0, 0,  0,  2,  1,   0,  2'b00};
        vecs[1] = '{1,  1,  -1, 1, 1,  0,  1,  1,   0,  2'b00};
        vecs[2] = '{0,  0,  -1, 0, 0,  0,  0,  0,   1,  2'b01};
        vecs[3] = '{65, 0,  -1, 0, 0,  0,  0,  0,   1,  2'b01};
        vecs[4] = '{3,  3,  1,  0, 0,  0,  1,  0,   1,  2'b10};
        vecs[5] = '{4,  4,  -1, 0, 0,  1,  4,  1,   0,  2'b00};
        vecs[6] = '{64, 64, -1, 0, 0,  0,  64, 1,   0,  2'b00};
        vecs[7] = '{2,  2,  0,  1, 0,  1,  0,  0,   1,  2'b10};

        for (int v = 0; v < 8; v++) begin
            stream.delete();
            if (vecs[v].false_start) push_bits(16'hB, 4);
            push_bits(16'h00B2, 8);
            push_bits(16'(vecs[v].n_len), 16);
            for (int f = 0; f < vecs[v].n_frames; f++)
                push_frame(vecs[v].fixed_payload ? 37'h0_0000_0116 : rand_payload(),
                           f == vecs[v].bad_frame);
            prog_pulse();
            run_stream(vecs[v].gaps);
            check("tbl_nwr",  64'(m_addr.size()), 64'(vecs[v].exp_nwr));
            check("tbl_done", 64'(DONE),          64'(vecs[v].exp_done));
            check("tbl_err",  64'(ERR),           64'(vecs[v].exp_err));
            check("tbl_code", 64'(ERR_CODE),      64'(vecs[v].exp_code));
            if (vecs[v].fixed_payload && m_data.size() > 0)
                check("fixed_payload", 64'(m_data[0]), 64'(37'h0_0000_0116));
        end

        // Randomized streams: junk prefix, random N, occasional bad frame.
        for (int r = 0; r < 8; r++) begin
            int n, bad, nj;
            stream.delete();
            nj = int'($urandom_range(0, 12));
            for (int j = 0; j < nj; j++) stream.push_back(1'($urandom()));
            push_bits(16'h00B2, 8);
            n   = int'($urandom_range(1, 6));
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            push_bits(16'(n), 16);
            for (int f = 0; f < n; f++) push_frame(rand_payload(), f == bad);
            prog_pulse();
            run_stream(1'($urandom()));
        end

        // RST on bit 20 of frame 0: no write, all outputs cleared.
        stream.delete();
        prog_pulse();
        clear_monitor();
        push_bits(16'h00B2, 8);
        push_bits(16'd2, 16);
        for (int i = 0; i < stream.size(); i++) drive_bit(stream[i]);
        for (int i = 0; i < 19; i++) drive_bit(1'($urandom()));
        check("busy_before_rst", 64'(BUSY), 64'(1));
        RST = 1'b1; DIN = 1'b1; DIN_VALID = 1'b1;
        @(posedge K); #1;
        RST = 1'b0; DIN_VALID = 1'b0;
        check("outputs_after_rst", 64'({CFG_WE, CFG_ADDR, CFG_DATA, BUSY, DONE, ERR, ERR_CODE}), 64'(0));
        for (int i = 0; i < 40; i++) drive_bit(1'b1);
        idle(2);
        check("no_we_after_rst", 64'(m_addr.size()), 64'(0));
        check("idle_after_rst",  64'(BUSY),          64'(0));

        // PROG coincident with the final preamble bit discards that bit.
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
        drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
        PROG = 1'b1; DIN = 1'b0; DIN_VALID = 1'b1;
        @(posedge K); #1;
        PROG = 1'b0; DIN_VALID = 1'b0;
        idle(1);
        check("prog_discards_bit", 64'(BUSY), 64'(0));
        stream.delete();
        stream.push_back(1'b0);
        idle(1);
        push_bits(16'h00B2, 8);
        push_bits(16'd1, 16);
        push_frame(rand_payload(), 1'b0);
        run_stream(1'b0);
        check("resent_preamble_done", 64'(DONE), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
